// File: rtl/alu_result_tx.sv
// alu_result_tx: snapshots ALU result/flags on i_start and sends them
// as two bytes through a start/done handshake with the TX serializer.
module alu_result_tx #(
  parameter  int NB_DATA        = 8,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int NB_TMO         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_RES,
    S_WAIT_RES,
    S_SEND_FLG,
    S_WAIT_FLG
  } state_t;

  localparam logic [NB_TMO-1:0] TMO_LAST =
    NB_TMO'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [NB_DATA-1:0]  r_res;
  logic [7:0]          r_flg;
  logic [NB_TMO-1:0]   r_cnt;
  logic [NB_TMO-1:0]   w_cnt;
  logic [7:0]          r_tx_data;
  logic [7:0]          w_tx_data;
  logic                r_done;
  logic                r_timeout;
  logic                w_done;
  logic                w_timeout;
  logic                w_capture;
  logic                w_cnt_last;

  assign w_cnt_last = (r_cnt == TMO_LAST);

  always_comb begin
    w_next    = r_state;
    w_cnt     = r_cnt;
    w_tx_data = r_tx_data;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    w_capture = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next    = S_SEND_RES;
          w_capture = 1'b1;
          w_tx_data = i_alu_result;
        end
      end
      S_SEND_RES: begin
        w_next = S_WAIT_RES;
        w_cnt  = '0;
      end
      S_WAIT_RES: begin
        // done on the last allowed cycle still beats the timeout
        if (i_tx_done) begin
          w_next    = S_SEND_FLG;
          w_tx_data = r_flg;
        end else if (w_cnt_last) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt + NB_TMO'(1);
        end
      end
      S_SEND_FLG: begin
        w_next = S_WAIT_FLG;
        w_cnt  = '0;
      end
      S_WAIT_FLG: begin
        if (i_tx_done) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end else if (w_cnt_last) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end else begin
          w_cnt = r_cnt + NB_TMO'(1);
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_res     <= '0;
      r_flg     <= '0;
      r_cnt     <= '0;
      r_tx_data <= '0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_tx_data <= w_tx_data;
      r_done    <= w_done;
      r_timeout <= w_timeout;
      if (w_capture) begin
        r_res <= i_alu_result;
        r_flg <= {6'b0, i_alu_carry, i_alu_zero};
      end
    end
  end

  assign o_tx_start = (r_state == S_SEND_RES) ||
                      (r_state == S_SEND_FLG);
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;
  assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_alu_result_tx.sv
// tb_alu_result_tx: directed and random transfers against a
// transfer-level model of bytes sent, done and timeout pulses.
module tb_alu_result_tx;

  localparam int T = 16;

  logic       i_clk;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_alu_result;
  logic       i_alu_carry;
  logic       i_alu_zero;
  logic       i_tx_done;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_done;
  logic       o_timeout;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_tmo    = 0;
  logic [7:0] q_sent[$];

  alu_result_tx #(
    .NB_DATA(8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_alu_result(i_alu_result),
    .i_alu_carry (i_alu_carry),
    .i_alu_zero  (i_alu_zero),
    .i_tx_done   (i_tx_done),
    .o_tx_start  (o_tx_start),
    .o_tx_data   (o_tx_data),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_timeout   (o_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance to the next falling edge and record output events
  task automatic tick();
    @(negedge i_clk);
    if (o_tx_start) q_sent.push_back(o_tx_data);
    if (o_done) n_done++;
    if (o_timeout) n_tmo++;
  endtask

  // answer a pending byte with done d cycles after its start
  task automatic byte_wait(input int d, input bit poke,
                           input logic [7:0] b);
    for (int i = 0; i < d; i++) begin
      i_start = poke && (i == 1);
      if (poke && i == 1) begin
        i_alu_result = 8'($urandom);
        i_alu_carry  = ~i_alu_carry;
        i_alu_zero   = ~i_alu_zero;
      end
      tick();
    end
    i_start = 1'b0;
    chk("hold_data", o_tx_data, b);
    chk("busy_wait", o_busy, 1);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] res, input logic c, z,
                      input int d1, d2,
                      input bit scramble, poke, rst_mid);
    logic [7:0] flg;
    int base, d0, t0, n_exp, done_exp, tmo_exp;
    flg  = {6'b0, c, z};
    base = q_sent.size();
    d0   = n_done;
    t0   = n_tmo;
    i_alu_result = res;
    i_alu_carry  = c;
    i_alu_zero   = z;
    i_start      = 1'b1;
    tick();
    i_start = 1'b0;
    if (scramble) begin
      i_alu_result = 8'hFF;
      i_alu_carry  = 1'b1;
      i_alu_zero   = 1'b1;
    end
    chk("start_latency", o_tx_start, 1);
    chk("byte0_data", o_tx_data, res);
    n_exp = 1;
    if (d1 <= T) begin
      byte_wait(d1, poke, res);
      chk("start1", o_tx_start, 1);
      chk("byte1_data", o_tx_data, flg);
      n_exp = 2;
      if (rst_mid) begin
        tick();
        tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("rst_start", o_tx_start, 0);
        chk("rst_data", o_tx_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_tmo", o_timeout, 0);
      end else if (d2 <= T) begin
        byte_wait(d2, 1'b0, flg);
      end
    end
    for (int i = 0; i < 3 * T && o_busy; i++) tick();
    chk("idle_bound", o_busy, 0);
    tick();
    tick();
    done_exp = (!rst_mid && d1 <= T && d2 <= T) ? 1 : 0;
    tmo_exp  = (!rst_mid && (d1 > T || d2 > T)) ? 1 : 0;
    chk("n_bytes", q_sent.size() - base, n_exp);
    chk("sent0", q_sent[base], res);
    if (n_exp == 2) chk("sent1", q_sent[base + 1], flg);
    chk("n_done", n_done - d0, done_exp);
    chk("n_timeout", n_tmo - t0, tmo_exp);
  endtask

  initial begin
    int base;
    i_reset      = 1'b1;
    i_start      = 1'b0;
    i_alu_result = 8'h00;
    i_alu_carry  = 1'b0;
    i_alu_zero   = 1'b0;
    i_tx_done    = 1'b0;
    tick();
    tick();
    chk("reset_start", o_tx_start, 0);
    chk("reset_data", o_tx_data, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_tmo", o_timeout, 0);
    i_reset = 1'b0;
    tick();

    xfer(8'h3C, 1'b1, 1'b0, 5, 5, 1'b0, 1'b0, 1'b0);
    xfer(8'h00, 1'b0, 1'b1, 5, 5, 1'b1, 1'b0, 1'b0);
    xfer(8'hA5, 1'b1, 1'b1, 1000, 1000, 1'b0, 1'b0, 1'b0);
    xfer(8'h5A, 1'b0, 1'b0, T, T, 1'b0, 1'b0, 1'b0);
    xfer(8'h11, 1'b0, 1'b1, 3, T + 1, 1'b0, 1'b0, 1'b0);
    xfer(8'h22, 1'b1, 1'b0, 1, 1, 1'b0, 1'b0, 1'b0);

    base = q_sent.size();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    tick();
    tick();
    chk("stray_done_start", q_sent.size() - base, 0);
    chk("stray_done_busy", o_busy, 0);
    xfer(8'h77, 1'b1, 1'b0, 4, 3, 1'b0, 1'b1, 1'b0);

    xfer(8'hC3, 1'b1, 1'b1, 3, 5, 1'b0, 1'b0, 1'b1);
    xfer(8'h9E, 1'b0, 1'b1, 2, 2, 1'b0, 1'b0, 1'b0);

    repeat (12) begin
      xfer(8'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(1, T + 2), $urandom_range(1, T + 2),
           1'($urandom), 1'($urandom), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
